// File: rtl/outport_hs.sv
// Buffered output port: processor writes are queued in a small FIFO and sent to an
// asynchronous peripheral over a 4-phase req/ack handshake; status readback and drain interrupt.
module outport_hs #(
    parameter logic [7:0] ADDR      = 8'h00,
    parameter logic [7:0] STAT_ADDR = 8'h01,
    parameter int         WIDTH     = 8,
    parameter int         DEPTH     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       address,
    input  logic [WIDTH-1:0] value_in,
    input  logic             wen,
    input  logic             ren,
    input  logic             int_en,
    output logic [WIDTH-1:0] port_out,
    output logic             port_req,
    input  logic             port_ack,
    output logic [7:0]       status_out,
    output logic             int_out
);

    // Handshake: port_out is loaded on IDLE->SETUP, port_req rises one cycle later on
    // SETUP->REQ, falls once the synchronized ack is seen high, and the transfer
    // completes when the synchronized ack returns low.
    localparam int         PW      = (DEPTH == 4) ? 2 : 1;
    localparam logic [2:0] DEPTH_C = 3'(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        REQ     = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [2:0]       count;
    logic             ack_s1, ack_s;
    logic             overflow;
    logic             full, empty;
    logic             push, drop, pop, stat_rd, done, req_nxt;

    assign full    = (count == DEPTH_C);
    assign empty   = (count == 3'd0);
    assign push    = wen && (address == ADDR) && !full;
    assign drop    = wen && (address == ADDR) && full;
    assign stat_rd = ren && (address == STAT_ADDR);

    always_comb begin
        state_nxt = state;
        req_nxt   = port_req;
        pop       = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                req_nxt   = 1'b1;
                state_nxt = REQ;
            end
            REQ: begin
                if (ack_s) begin
                    req_nxt   = 1'b0;
                    state_nxt = RELEASE;
                end
            end
            RELEASE: begin
                if (!ack_s) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            port_req <= 1'b0;
            port_out <= '0;
        end else begin
            state    <= state_nxt;
            port_req <= req_nxt;
            if (pop) begin
                port_out <= mem[rd_ptr];
            end
        end
    end

    // Two-flop synchronizer for the asynchronous acknowledge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_s1 <= 1'b0;
            ack_s  <= 1'b0;
        end else begin
            ack_s1 <= port_ack;
            ack_s  <= ack_s1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= value_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= 3'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    // Sticky flags: a set event on the same edge as a status read wins over the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_out    <= 1'b0;
            overflow   <= 1'b0;
            status_out <= 8'h00;
        end else begin
            if (done && empty && !push && int_en) begin
                int_out <= 1'b1;
            end else if (stat_rd) begin
                int_out <= 1'b0;
            end
            if (drop) begin
                overflow <= 1'b1;
            end else if (stat_rd) begin
                overflow <= 1'b0;
            end
            if (stat_rd) begin
                status_out <= {count, 1'b0, int_out, overflow, full, empty};
            end
        end
    end

endmodule

// File: tb/tb_outport_hs.sv
// Directed bench for outport_hs: FIFO fill/overflow, handshake timing, interrupt and
// status read/clear behaviour, and asynchronous reset mid-transfer.
module tb_outport_hs;

    localparam logic [7:0] ADDR      = 8'h00;
    localparam logic [7:0] STAT_ADDR = 8'h01;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] address = 8'h00;
    logic [7:0] value_in = 8'h00;
    logic       wen = 1'b0;
    logic       ren = 1'b0;
    logic       int_en = 1'b0;
    logic [7:0] port_out;
    logic       port_req;
    logic       port_ack;
    logic [7:0] status_out;
    logic       int_out;

    logic       ack_auto = 1'b0;
    logic       ack_model = 1'b0;
    logic       ack_manual = 1'b0;

    int checks = 0;
    int failures = 0;

    assign port_ack = ack_auto ? ack_model : ack_manual;

    outport_hs #(
        .ADDR(ADDR),
        .STAT_ADDR(STAT_ADDR),
        .WIDTH(8),
        .DEPTH(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .address(address),
        .value_in(value_in),
        .wen(wen),
        .ren(ren),
        .int_en(int_en),
        .port_out(port_out),
        .port_req(port_req),
        .port_ack(port_ack),
        .status_out(status_out),
        .int_out(int_out)
    );

    // clock / reset
    always #5 clk = ~clk;

    // peripheral model: mirrors port_req onto ack three cycles after each req edge
    initial begin
        forever begin
            @(port_req);
            repeat (3) @(posedge clk);
            #1 ack_model = port_req;
        end
    end

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%02h exp=%02h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] data);
        address  = ADDR;
        value_in = data;
        wen      = 1'b1;
        tick();
        wen      = 1'b0;
    endtask

    task automatic rd_status();
        address = STAT_ADDR;
        ren     = 1'b1;
        tick();
        ren     = 1'b0;
        address = ADDR;
    endtask

    task automatic wait_req(input logic lvl);
        int n = 0;
        while (port_req !== lvl && n < 20) begin
            tick();
            n++;
        end
        check("req_wait", {7'd0, port_req}, {7'd0, lvl});
    endtask

    task automatic deliver_one(input logic [7:0] exp);
        wait_req(1'b1);
        check("deliver_data", port_out, exp);
        ack_manual = 1'b1;
        wait_req(1'b0);
        ack_manual = 1'b0;
    endtask

    initial begin
        logic [7:0] seq3 [5];
        seq3 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_req", {7'd0, port_req}, 8'h00);
        check("rst_out", port_out, 8'h00);
        check("rst_status", status_out, 8'h00);
        check("rst_int", {7'd0, int_out}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        rd_status();
        check("status_after_rst", status_out, 8'h01);

        // single byte with auto-ack and drain interrupt
        int_en   = 1'b1;
        ack_auto = 1'b1;
        wr(8'hA5);
        check("a5_req_t0", {7'd0, port_req}, 8'h00);
        tick();
        check("a5_data_t1", port_out, 8'hA5);
        check("a5_req_t1", {7'd0, port_req}, 8'h00);
        tick();
        check("a5_req_t2", {7'd0, port_req}, 8'h01);
        repeat (5) tick();
        check("a5_req_t7", {7'd0, port_req}, 8'h01);
        tick();
        check("a5_req_t8", {7'd0, port_req}, 8'h00);
        repeat (5) tick();
        check("a5_int_t13", {7'd0, int_out}, 8'h00);
        tick();
        check("a5_int_t14", {7'd0, int_out}, 8'h01);
        rd_status();
        check("a5_status", status_out, 8'h09);
        check("a5_int_clr", {7'd0, int_out}, 8'h00);
        ack_auto = 1'b0;
        int_en   = 1'b0;
        repeat (4) tick();

        // fill, overflow, ordered drain
        wr(8'h11);
        tick();
        tick();
        check("fill_req", {7'd0, port_req}, 8'h01);
        wr(8'h22);
        wr(8'h33);
        wr(8'h44);
        wr(8'h55);
        rd_status();
        check("fill_status", status_out, 8'h82);
        wr(8'h66);
        rd_status();
        check("ovf_status", status_out, 8'h86);
        rd_status();
        check("ovf_cleared", status_out, 8'h82);
        for (int i = 0; i < 5; i++) begin
            deliver_one(seq3[i]);
        end
        repeat (8) tick();
        check("no_66_req", {7'd0, port_req}, 8'h00);
        rd_status();
        check("drained_status", status_out, 8'h01);

        // status read coinciding with transfer complete
        int_en = 1'b1;
        wr(8'h77);
        tick();
        check("t4_data", port_out, 8'h77);
        tick();
        check("t4_req_up", {7'd0, port_req}, 8'h01);
        ack_manual = 1'b1;
        tick();
        tick();
        check("t4_req_hold", {7'd0, port_req}, 8'h01);
        tick();
        check("t4_req_down", {7'd0, port_req}, 8'h00);
        ack_manual = 1'b0;
        tick();
        tick();
        check("t4_int_pre", {7'd0, int_out}, 8'h00);
        rd_status();
        check("t4_status", status_out, 8'h01);
        check("t4_int_set_wins", {7'd0, int_out}, 8'h01);

        // status read with both sticky flags set
        int_en = 1'b0;
        wr(8'h01);
        tick();
        tick();
        wr(8'h02);
        wr(8'h03);
        wr(8'h04);
        wr(8'h05);
        wr(8'h06);
        rd_status();
        check("t5_status", status_out, 8'h8E);
        check("t5_int_clr", {7'd0, int_out}, 8'h00);
        rd_status();
        check("t5_status2", status_out, 8'h82);
        deliver_one(8'h01);
        deliver_one(8'h02);
        deliver_one(8'h03);
        deliver_one(8'h04);
        deliver_one(8'h05);
        repeat (6) tick();

        // push on the same edge as the IDLE pop
        wr(8'hA1);
        tick();
        tick();
        wr(8'hB2);
        check("t6_data_a1", port_out, 8'hA1);
        ack_manual = 1'b1;
        wait_req(1'b0);
        ack_manual = 1'b0;
        repeat (3) tick();
        wr(8'hC3);
        check("t6_data_b2", port_out, 8'hB2);
        rd_status();
        check("t6_status", status_out, 8'h20);
        deliver_one(8'hB2);
        deliver_one(8'hC3);
        repeat (6) tick();

        // asynchronous reset mid-REQ with three queued entries
        int_en = 1'b1;
        wr(8'hD1);
        tick();
        tick();
        wr(8'hD2);
        wr(8'hD3);
        wr(8'hD4);
        rd_status();
        check("t7_status_pre", status_out, 8'h60);
        check("t7_req_pre", {7'd0, port_req}, 8'h01);
        #3 rst_n = 1'b0;
        #1;
        check("t7_req_rst", {7'd0, port_req}, 8'h00);
        check("t7_int_rst", {7'd0, int_out}, 8'h00);
        check("t7_status_rst", status_out, 8'h00);
        check("t7_out_rst", port_out, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        rd_status();
        check("t7_status_post", status_out, 8'h01);
        repeat (4) tick();
        check("t7_req_post", {7'd0, port_req}, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
